// File: rtl/ctrl_74x393_seq.sv
// Sequencer for one bank of a MOD_74x393 ripple counter: drives its clock and
// clear, checks Q against an internal expected count, and divides modulo MOD_N+1.
module ctrl_74x393_seq #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] MOD_N,
  input  logic [7:0]       CYCLES,
  input  logic [WIDTH-1:0] Q,
  output logic             CNT_CLK,
  output logic             CNT_CLR,
  output logic             BUSY,
  output logic             TC,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] EXP
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FALL  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [2:0]       state, state_next;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] mod_r;
  logic [7:0]       cycles_r;
  logic [7:0]       term_cnt;
  logic [7:0]       term_inc;
  logic             terminal;
  logic             settled;

  assign terminal = (mod_r != '0) ? (EXP == mod_r) : (EXP == '1);
  assign settled  = (wait_cnt == SETTLE_LAST);
  assign term_inc = term_cnt + 8'd1;

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (START) state_next = S_CLEAR;
      S_CLEAR: state_next = S_WAIT;
      S_FALL:  state_next = S_WAIT;
      S_WAIT:  if (settled) state_next = S_CHECK;
      S_CHECK: begin
        if (DONE || STOP)              state_next = S_IDLE;
        else if (TC && mod_r != '0)    state_next = S_CLEAR;
        else                           state_next = S_FALL;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from state_next so they are valid for the whole
  // cycle of the state they belong to; the CHECK verdict is taken on the last
  // WAIT edge so TC/DONE/ERR show during CHECK and the exit decision uses them.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mod_r    <= '0;
      cycles_r <= '0;
      term_cnt <= '0;
      CNT_CLK  <= 1'b1;
      CNT_CLR  <= 1'b0;
      BUSY     <= 1'b0;
      TC       <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      EXP      <= '0;
    end else begin
      state    <= state_next;
      CNT_CLK  <= (state_next != S_FALL);
      CNT_CLR  <= (state_next == S_CLEAR);
      BUSY     <= (state_next != S_IDLE);
      TC       <= 1'b0;
      DONE     <= 1'b0;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;

      if (state == S_IDLE && START) begin
        mod_r    <= MOD_N;
        cycles_r <= CYCLES;
        ERR      <= 1'b0;
        term_cnt <= '0;
      end

      if (state_next == S_CLEAR)     EXP <= '0;
      else if (state_next == S_FALL) EXP <= EXP + WIDTH'(1);

      if (state == S_WAIT && settled) begin
        if (Q != EXP) ERR <= 1'b1;
        if (terminal) begin
          TC       <= 1'b1;
          term_cnt <= term_inc;
          if (cycles_r != 8'd0 && term_inc == cycles_r) DONE <= 1'b1;
        end
      end
    end
  end

endmodule
